path_delay_meter: RTL and testbench
===================================

PATH_DELAY_METER -- requirements
Module: path_delay_meter

Interface
REQ-001 Parameter CNT_W, default 16, width of the per-trial delay counter.
REQ-002 Parameter TRIALS, default 8, launches per batch; power of two, 1..256.
REQ-003 Parameter TIMEOUT, default 1000, max counted cycles per trial; 3 <= TIMEOUT < 2^CNT_W.
REQ-004 Parameter SETTLE, default 16, idle cycles before each launch; >= 1.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  batch request, sampled only in IDLE.
REQ-008 pathInput  output  1  registered launch signal driving the delay-chain input.
REQ-009 pathResult  input  1  delay-chain output, asynchronous to clk.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 resultValid  output  1  batch results available.
REQ-012 resultReady  input  1  consumer accepts results.
REQ-013 delaySum  output  CNT_W+log2(TRIALS)  sum of per-trial counts.
REQ-014 delayMin  output  CNT_W  smallest per-trial count.
REQ-015 delayMax  output  CNT_W  largest per-trial count.
REQ-016 timeoutFlag  output  1  at least one trial in the batch timed out.

Function
REQ-017 pathResult passes through a 2-flop synchronizer (sync1, sync2); only sync2 is used internally.
REQ-018 FSM states: IDLE, SETTLE, MEASURE, DONE.
REQ-019 IDLE -> SETTLE when start=1; trial index, delaySum, delayMax and timeoutFlag clear to 0, delayMin sets to all ones.
REQ-020 SETTLE counts SETTLE cycles; on its final cycle baseline <= sync2, pathInput toggles, the trial counter clears to 0, and the state moves to MEASURE.
REQ-021 In MEASURE, each cycle with sync2 == baseline and counter < TIMEOUT-1 increments the counter.
REQ-022 Arrival: the first MEASURE cycle with sync2 != baseline records count = counter value.
REQ-023 Timeout: counter == TIMEOUT-1 with no arrival records count = TIMEOUT and sets timeoutFlag (sticky for the batch).
REQ-024 On record: delaySum += count, delayMin = min(delayMin, count), delayMax = max(delayMax, count); the update is applied in the same cycle.
REQ-025 After a record: if trial index < TRIALS-1, the index increments and the state moves to SETTLE; otherwise the state moves to DONE.
REQ-026 A path with zero delay records count = 2 (synchronizer floor); a path delaying by D full cycles records D+2.
REQ-027 delaySum cannot overflow, because its width covers TRIALS*TIMEOUT.
REQ-028 DONE: resultValid=1; delaySum, delayMin, delayMax and timeoutFlag are held stable.
REQ-029 DONE -> IDLE on resultValid && resultReady; resultValid drops the next cycle.
REQ-030 start is ignored outside IDLE, including the handshake cycle.
REQ-031 Result outputs retain their last values in IDLE until the next accepted start.
REQ-032 pathInput changes only at the launch edge (REQ-020) and alternates level every trial, with no glitches.

Reset
REQ-033 rst_n=0 immediately forces IDLE, with pathInput=0, busy=0, resultValid=0, delaySum=0, delayMin=0, delayMax=0, timeoutFlag=0, and synchronizer, baseline and counters at 0.
REQ-034 Reset asserted mid-batch aborts the batch, produces no resultValid, and discards partial results.
REQ-035 The first start after reset deassertion is honoured in the first IDLE cycle.

Verification
REQ-036 Path modelled as a 5-cycle register delay, TRIALS=8, start pulse -> delaySum=56, delayMin=7, delayMax=7, timeoutFlag=0, resultValid after 8 trials.
REQ-037 pathResult tied to 0 (no transition), TIMEOUT=1000 -> every trial records 1000, delaySum=8000, delayMin=delayMax=1000, timeoutFlag=1.
REQ-038 Model delay alternating 3 and 10 cycles per trial -> delayMin=5, delayMax=12, delaySum=68.
REQ-039 resultReady held 0 for 20 cycles in DONE -> resultValid and outputs stable for all 20 cycles; pulsing start during those cycles has no effect; resultReady=1 -> IDLE next cycle.
REQ-040 rst_n pulsed low during trial 4 -> pathInput=0, busy=0 and resultValid=0 at once; a new start runs a full clean batch matching REQ-036.
REQ-041 Zero-delay model (pathResult = pathInput) -> every count = 2, delaySum=16.

Source files
------------

// File: rtl/path_delay_meter_if.sv
// Bus between the path delay meter and its environment: launch/capture pins,
// batch request and the batch result handshake.
interface path_delay_meter_if #(
  parameter int CNT_W  = 16,
  parameter int TRIALS = 8
);
  localparam int SUM_W = CNT_W + $clog2(TRIALS);

  logic             start;
  logic             pathInput;
  logic             pathResult;
  logic             busy;
  // Result handshake: a batch result transfers on the first rising edge where
  // resultValid && resultReady. Once raised, resultValid stays high and
  // delaySum/delayMin/delayMax/timeoutFlag stay constant until that transfer;
  // resultReady may be driven freely and never depends on resultValid.
  logic             resultValid;
  logic             resultReady;
  logic [SUM_W-1:0] delaySum;
  logic [CNT_W-1:0] delayMin;
  logic [CNT_W-1:0] delayMax;
  logic             timeoutFlag;

  modport master (
    input  start, pathResult, resultReady,
    output pathInput, busy, resultValid, delaySum, delayMin, delayMax, timeoutFlag
  );

  modport slave (
    output start, pathResult, resultReady,
    input  pathInput, busy, resultValid, delaySum, delayMin, delayMax, timeoutFlag
  );
endinterface

// File: rtl/path_delay_meter.sv
// Measures the propagation delay of an external path in clock cycles over a
// batch of TRIALS launches, reporting sum, minimum, maximum and timeout.
module path_delay_meter #(
  parameter int CNT_W   = 16,
  parameter int TRIALS  = 8,
  parameter int TIMEOUT = 1000,
  parameter int SETTLE  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  path_delay_meter_if.master  bus,
  output logic [1:0]          dbg_state_o
);

  localparam int SUM_W = CNT_W + $clog2(TRIALS);
  localparam int IDX_W = (TRIALS > 1) ? $clog2(TRIALS) : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CNT_W-1:0] TMO_C     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_M1    = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(TRIALS - 1);
  localparam logic [SET_W-1:0] SETTLE_M1 = SET_W'(SETTLE - 1);

  if (TRIALS < 1 || TRIALS > 256 || (TRIALS & (TRIALS - 1)) != 0) begin : g_bad_trials
    $error("path_delay_meter: TRIALS must be a power of two in 1..256");
  end
  if (TIMEOUT < 3 || TIMEOUT >= (2 ** CNT_W)) begin : g_bad_timeout
    $error("path_delay_meter: TIMEOUT must satisfy 3 <= TIMEOUT < 2**CNT_W");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("path_delay_meter: SETTLE must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             baseline_q, baseline_d;
  logic             path_q, path_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             tflag_q, tflag_d;

  logic             arrive;
  logic             tmo;
  logic             record;
  logic [CNT_W-1:0] count_val;

  // Arrival wins over timeout when both happen on the last counted cycle.
  assign arrive    = (sync2_q != baseline_q);
  assign tmo       = !arrive && (cnt_q == TMO_M1);
  assign record    = (state_q == S_MEASURE) && (arrive || tmo);
  assign count_val = arrive ? cnt_q : TMO_C;

  always_comb begin
    state_d    = state_q;
    baseline_d = baseline_q;
    path_d     = path_q;
    settle_d   = settle_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    min_d      = min_q;
    max_d      = max_q;
    tflag_d    = tflag_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_SETTLE;
          settle_d = '0;
          idx_d    = '0;
          sum_d    = '0;
          min_d    = '1;
          max_d    = '0;
          tflag_d  = 1'b0;
        end
      end

      S_SETTLE: begin
        if (settle_q == SETTLE_M1) begin
          baseline_d = sync2_q;
          path_d     = ~path_q;
          cnt_d      = '0;
          state_d    = S_MEASURE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      S_MEASURE: begin
        if (record) begin
          sum_d   = sum_q + SUM_W'(count_val);
          min_d   = (count_val < min_q) ? count_val : min_q;
          max_d   = (count_val > max_q) ? count_val : max_q;
          tflag_d = tflag_q | tmo;
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d    = idx_q + 1'b1;
            settle_d = '0;
            state_d  = S_SETTLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        if (bus.resultReady) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      baseline_q <= 1'b0;
      path_q     <= 1'b0;
      settle_q   <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      tflag_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= bus.pathResult;
      sync2_q    <= sync1_q;
      baseline_q <= baseline_d;
      path_q     <= path_d;
      settle_q   <= settle_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      min_q      <= min_d;
      max_q      <= max_d;
      tflag_q    <= tflag_d;
    end
  end

  assign bus.pathInput   = path_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.resultValid = (state_q == S_DONE);
  assign bus.delaySum    = sum_q;
  assign bus.delayMin    = min_q;
  assign bus.delayMax    = max_q;
  assign bus.timeoutFlag = tflag_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_path_delay_meter.sv
// Bench for path_delay_meter: an external path model with selectable delay,
// a result scoreboard, handshake stalls and a mid-batch reset.
module tb_path_delay_meter;
  localparam int CNT_W   = 16;
  localparam int TRIALS  = 8;
  localparam int TIMEOUT = 1000;
  localparam int SETTLE  = 16;
  localparam int SUM_W   = CNT_W + $clog2(TRIALS);
  localparam int W       = SUM_W + 2 * CNT_W + 1;
  localparam int D_FIX   = 5;
  localparam int D_ODD   = 3;
  localparam int D_EVEN  = 10;
  localparam int WAIT_MAX = 30000;

  // Path model modes
  localparam int M_ZERO = 0;
  localparam int M_FIX  = 1;
  localparam int M_TIE0 = 2;
  localparam int M_ALT  = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  path_delay_meter_if #(.CNT_W(CNT_W), .TRIALS(TRIALS)) bus ();
  logic [1:0] dbg_state;

  path_delay_meter #(
    .CNT_W(CNT_W), .TRIALS(TRIALS), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.master),
    .dbg_state_o(dbg_state)
  );

  // ---------------- path model ----------------
  int          mode = M_FIX;
  logic [15:0] dl   = '0;
  logic        pr;

  always @(posedge clk) dl <= {dl[14:0], bus.pathInput};

  always_comb begin
    pr = 1'b0;
    case (mode)
      M_ZERO:  pr = bus.pathInput;
      M_FIX:   pr = dl[D_FIX-1];
      M_TIE0:  pr = 1'b0;
      default: pr = bus.pathInput ? dl[D_ODD-1] : dl[D_EVEN-1];
    endcase
  end
  assign bus.pathResult = pr;

  int   launches = 0;
  logic prev_pi  = 1'b0;
  always @(posedge clk) begin
    if (bus.pathInput !== prev_pi) launches <= launches + 1;
    prev_pi <= bus.pathInput;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp;
  int           base_launch;

  task automatic push_expected(input int m);
    logic [SUM_W-1:0] s;
    logic [CNT_W-1:0] mn;
    logic [CNT_W-1:0] mx;
    int               c;
    s  = '0;
    mn = '1;
    mx = '0;
    for (int i = 0; i < TRIALS; i++) begin
      case (m)
        M_ZERO:  c = 2;
        M_FIX:   c = D_FIX + 2;
        M_TIE0:  c = TIMEOUT;
        default: c = (i % 2 == 0) ? D_ODD + 2 : D_EVEN + 2;
      endcase
      s = s + SUM_W'(c);
      if (CNT_W'(c) < mn) mn = CNT_W'(c);
      if (CNT_W'(c) > mx) mx = CNT_W'(c);
    end
    exp_q.push_back({s, mn, mx, (m == M_TIE0) ? 1'b1 : 1'b0});
  endtask

  task automatic compare_outputs(input string tag);
    check({tag, "_sum"},  64'(bus.delaySum),    64'(cur_exp[W-1 -: SUM_W]));
    check({tag, "_min"},  64'(bus.delayMin),    64'(cur_exp[2*CNT_W : CNT_W+1]));
    check({tag, "_max"},  64'(bus.delayMax),    64'(cur_exp[CNT_W:1]));
    check({tag, "_tflg"}, 64'(bus.timeoutFlag), 64'(cur_exp[0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_batch(input int m);
    mode = m;
    push_expected(m);
    base_launch = launches;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    check("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_result(input string tag);
    int n;
    n = 0;
    while (!bus.resultValid && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    if (!bus.resultValid) check({tag, "_valid_timeout"}, 64'd0, 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      cur_exp = exp_q.pop_front();
      compare_outputs(tag);
      check({tag, "_launches"}, 64'(launches - base_launch), 64'(TRIALS));
    end
  endtask

  task automatic accept(input string tag, input int stall);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1 bus.start = (i == 5 || i == 6);
      @(negedge clk);
      check({tag, "_stall_valid"}, 64'(bus.resultValid), 64'd1);
      compare_outputs({tag, "_stall"});
    end
    @(posedge clk); #1 begin bus.resultReady = 1'b1; bus.start = 1'b1; end
    @(negedge clk);
    check({tag, "_valid_before_hs"}, 64'(bus.resultValid), 64'd1);
    @(posedge clk); #1 begin bus.resultReady = 1'b0; bus.start = 1'b0; end
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(bus.resultValid), 64'd0);
    check({tag, "_busy_drop"},  64'(bus.busy), 64'd0);
    check({tag, "_state_idle"}, 64'(dbg_state), 64'd0);
    repeat (3) @(negedge clk);
    compare_outputs({tag, "_idle_hold"});
  endtask

  // ---------------- main ----------------
  initial begin
    bus.start       = 1'b0;
    bus.resultReady = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pathInput", 64'(bus.pathInput),   64'd0);
    check("rst_busy",      64'(bus.busy),        64'd0);
    check("rst_valid",     64'(bus.resultValid), 64'd0);
    check("rst_sum",       64'(bus.delaySum),    64'd0);
    check("rst_min",       64'(bus.delayMin),    64'd0);
    check("rst_max",       64'(bus.delayMax),    64'd0);
    check("rst_tflag",     64'(bus.timeoutFlag), 64'd0);
    check("rst_state",     64'(dbg_state),       64'd0);
    rst_n = 1'b1;

    start_batch(M_FIX);  wait_result("fix5");  accept("fix5", 0);
    start_batch(M_ZERO); wait_result("zero");  accept("zero", 0);
    start_batch(M_ALT);  wait_result("alt");   accept("alt", 0);
    start_batch(M_FIX);  wait_result("stall"); accept("stall", 20);
    start_batch(M_TIE0); wait_result("tmo");   accept("tmo", 0);

    // Abort a batch part way through trial 4
    start_batch(M_FIX);
    for (int n = 0; n < WAIT_MAX && (launches - base_launch) < 4; n++) @(negedge clk);
    check("abort_reached_trial4", 64'((launches - base_launch) >= 4), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_pathInput", 64'(bus.pathInput),   64'd0);
    check("abort_busy",      64'(bus.busy),        64'd0);
    check("abort_valid",     64'(bus.resultValid), 64'd0);
    check("abort_sum",       64'(bus.delaySum),    64'd0);
    check("abort_min",       64'(bus.delayMin),    64'd0);
    check("abort_state",     64'(dbg_state),       64'd0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);

    // Start raised together with reset release is taken at the first edge
    rst_n       = 1'b1;
    mode        = M_FIX;
    push_expected(M_FIX);
    base_launch = launches;
    bus.start   = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 64'(bus.busy), 64'd1);
    wait_result("post_rst");
    accept("post_rst", 0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
